// File: rtl/instr_mem_pipelined.sv
// instr_mem_pipelined: instruction memory with valid/ready fetch, LATENCY-deep read pipeline, flush and loader port.
module instr_mem_pipelined #(
  parameter int          DEPTH    = 1024,
  parameter int          LATENCY  = 1,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        flush,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] r_mem [DEPTH] = '{default: NOP_WORD};
  logic        r_vld  [LATENCY];
  logic [31:0] r_data [LATENCY];
  logic [31:0] r_addr [LATENCY];
  logic        r_err  [LATENCY];
  logic        w_stall, w_adv, w_acc, w_req_err, w_ld_ok, w_unused;
  assign w_stall   = r_vld[LATENCY-1] && !rsp_ready;
  assign req_ready = flush || !w_stall;
  assign w_adv     = flush || !w_stall;
  assign w_acc     = req_valid && req_ready;
  // 32-bit compare so addresses like 0xFFFFFFFC never alias onto a low word
  assign w_req_err = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));
  assign w_ld_ok   = {2'b00, ld_addr[31:2]} < 32'(DEPTH);
  assign w_unused  = ^ld_addr[1:0];
  always_ff @(posedge clk)
    if (ld_we && w_ld_ok) r_mem[ld_addr[AW+1:2]] <= ld_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_data[i] <= NOP_WORD;
        r_addr[i] <= 32'h0;
        r_err[i]  <= 1'b0;
      end
    end else if (w_adv) begin
      r_vld[0]  <= w_acc;
      r_data[0] <= w_req_err ? NOP_WORD : r_mem[req_addr[AW+1:2]];
      r_addr[0] <= req_addr;
      r_err[0]  <= w_req_err;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]  <= r_vld[i-1] && !flush;
        r_data[i] <= r_data[i-1];
        r_addr[i] <= r_addr[i-1];
        r_err[i]  <= r_err[i-1];
      end
    end
  assign rsp_valid = r_vld[LATENCY-1];
  assign rsp_data  = r_data[LATENCY-1];
  assign rsp_addr  = r_addr[LATENCY-1];
  assign rsp_err   = r_err[LATENCY-1];
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// tb_instr_mem_pipelined: LATENCY=1 (index 0) and LATENCY=3 (index 1) instances, vector table, scoreboard and corner sequences.
module tb_instr_mem_pipelined;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic        req_valid [2], rsp_ready [2], flush [2], ld_we [2];
  logic        req_ready [2], rsp_valid [2], rsp_err [2];
  logic [31:0] req_addr [2], ld_addr [2], ld_data [2], rsp_data [2], rsp_addr [2];
  int n_cmp = 0, n_fail = 0;
  logic acc;
  int   tries;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic err;} exp_t;
  typedef struct {logic ld; logic [31:0] la; logic [31:0] ldat; logic rq; logic [31:0] addr; logic [31:0] data; logic err;} vec_t;
  vec_t tv [13];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_rsp(int s, string nm, logic [31:0] ea, logic [31:0] ed, logic ee);
    int i;
    i = 0;
    while (rsp_valid[s] !== 1'b1 && i < 8) begin
      @(negedge clk);
      i++;
    end
    if (rsp_valid[s] !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no response within 8 cycles", nm);
    end else begin
      chk({nm, ".addr"}, rsp_addr[s], ea);
      chk({nm, ".data"}, rsp_data[s], ed);
      chk({nm, ".err"}, {31'b0, rsp_err[s]}, {31'b0, ee});
    end
  endtask

  task automatic fetch(int s, logic [31:0] a, logic [31:0] ed, logic ee, string nm);
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_addr[s]  = a;
    @(negedge clk);
    req_valid[s] = 1'b0;
    wait_rsp(s, nm, a, ed, ee);
  endtask

  for (genvar g = 0; g < 2; g++) begin : sb
    exp_t q [$];
    logic [31:0] mm [1024];
    instr_mem_pipelined #(.DEPTH(1024), .LATENCY(g == 0 ? 1 : 3), .NOP_WORD(NOP)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .rsp_addr(rsp_addr[g]), .rsp_err(rsp_err[g]), .flush(flush[g]),
      .ld_we(ld_we[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g])
    );
    initial for (int i = 0; i < 1024; i++) mm[i] = NOP;
    // Sample 1 time unit before each rising edge: handshake, flush, accept, then loader write.
    always @(negedge clk) begin : p
      exp_t e;
      logic er;
      #4;
      if (rst) q.delete();
      else begin
        if (rsp_valid[g] && rsp_ready[g]) begin
          if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb%0d: unexpected response addr %h", g, rsp_addr[g]);
          end else begin
            e = q.pop_front();
            chk($sformatf("sb%0d.addr", g), rsp_addr[g], e.addr);
            chk($sformatf("sb%0d.data", g), rsp_data[g], e.data);
            chk($sformatf("sb%0d.err", g), {31'b0, rsp_err[g]}, {31'b0, e.err});
          end
        end
        if (flush[g]) q.delete();
        if (req_valid[g] && req_ready[g]) begin
          er     = (req_addr[g][1:0] != 2'b00) || (req_addr[g][31:12] != 20'h0);
          e.addr = req_addr[g];
          e.err  = er;
          e.data = er ? NOP : mm[req_addr[g][11:2]];
          q.push_back(e);
        end
        if (ld_we[g] && ld_addr[g][31:12] == 20'h0) mm[ld_addr[g][11:2]] = ld_data[g];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{1'b1, 32'h8,   32'h0062E233, 1'b0, 32'h0,        32'h0,        1'b0};
    tv[1]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h8,        32'h0062E233, 1'b0};
    tv[2]  = '{1'b1, 32'h8,   32'hDEADBEEF, 1'b1, 32'h8,        32'h0062E233, 1'b0};
    tv[3]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h8,        32'hDEADBEEF, 1'b0};
    tv[4]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h6,        NOP,          1'b1};
    tv[5]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h1000,     NOP,          1'b1};
    tv[6]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'hFFFFFFFC, NOP,          1'b1};
    tv[7]  = '{1'b1, 32'h1000, 32'h12345678, 1'b1, 32'h0,       NOP,          1'b0};
    tv[8]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h0,        NOP,          1'b0};
    tv[9]  = '{1'b0, 32'h0,   32'h0,        1'b1, 32'hFFC,      NOP,          1'b0};
    tv[10] = '{1'b1, 32'hFFE, 32'hCAFEF00D, 1'b0, 32'h0,        32'h0,        1'b0};
    tv[11] = '{1'b0, 32'h0,   32'h0,        1'b1, 32'hFFC,      32'hCAFEF00D, 1'b0};
    tv[12] = '{1'b0, 32'h0,   32'h0,        1'b1, 32'h2,        NOP,          1'b1};
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_addr[s] = 32'h0; rsp_ready[s] = 1'b1; flush[s] = 1'b0;
      ld_we[s] = 1'b0; ld_addr[s] = 32'h0; ld_data[s] = 32'h0;
    end
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst%0d.valid", s), {31'b0, rsp_valid[s]}, 32'h0);
      chk($sformatf("rst%0d.data", s), rsp_data[s], NOP);
      chk($sformatf("rst%0d.addr", s), rsp_addr[s], 32'h0);
      chk($sformatf("rst%0d.err", s), {31'b0, rsp_err[s]}, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rdy0", {31'b0, req_ready[0]}, 32'h1);
    chk("rdy1", {31'b0, req_ready[1]}, 32'h1);
    // LATENCY=1 back-to-back
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h0;
    @(negedge clk); #1;
    chk("b2b.v0", {31'b0, rsp_valid[0]}, 32'h1);
    chk("b2b.a0", rsp_addr[0], 32'h0);
    chk("b2b.d0", rsp_data[0], NOP);
    chk("b2b.e0", {31'b0, rsp_err[0]}, 32'h0);
    req_addr[0] = 32'h4;
    @(negedge clk); #1;
    chk("b2b.v1", {31'b0, rsp_valid[0]}, 32'h1);
    chk("b2b.a1", rsp_addr[0], 32'h4);
    req_valid[0] = 1'b0;
    @(negedge clk); #1;
    chk("b2b.idle", {31'b0, rsp_valid[0]}, 32'h0);
    // LATENCY=3 first-response timing
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h4;
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1 chk("lat3.c1", {31'b0, rsp_valid[1]}, 32'h0);
    @(negedge clk); #1 chk("lat3.c2", {31'b0, rsp_valid[1]}, 32'h0);
    @(negedge clk); #1 chk("lat3.c3", {31'b0, rsp_valid[1]}, 32'h1);
    chk("lat3.addr", rsp_addr[1], 32'h4);
    // vector table on both latencies
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 13; i++) begin
        @(negedge clk);
        ld_we[s] = tv[i].ld; ld_addr[s] = tv[i].la; ld_data[s] = tv[i].ldat;
        req_valid[s] = tv[i].rq; req_addr[s] = tv[i].addr;
        @(negedge clk);
        ld_we[s] = 1'b0; req_valid[s] = 1'b0;
        if (tv[i].rq) wait_rsp(s, $sformatf("vec%0d.%0d", s, i), tv[i].addr, tv[i].data, tv[i].err);
      end
    // back-pressure on LATENCY=3
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          tries = 0;
          req_valid[1] = 1'b1; req_addr[1] = 32'(i * 4);
          do begin
            #4 acc = req_ready[1];
            @(negedge clk);
            tries++;
          end while (!acc && tries < 20);
          if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL bp.accept: request %0d never accepted", i);
          end
        end
        req_valid[1] = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        rsp_ready[1] = 1'b0;
        #1;
        chk("bp.v", {31'b0, rsp_valid[1]}, 32'h1);
        chk("bp.rdy", {31'b0, req_ready[1]}, 32'h0);
        for (int c = 0; c < 4; c++) begin
          chk($sformatf("bp.hold%0d.a", c), rsp_addr[1], 32'h0);
          chk($sformatf("bp.hold%0d.d", c), rsp_data[1], NOP);
          chk($sformatf("bp.hold%0d.e", c), {31'b0, rsp_err[1]}, 32'h0);
          if (c < 3) begin
            @(negedge clk); #1;
            chk($sformatf("bp.rdy%0d", c), {31'b0, req_ready[1]}, 32'h0);
          end
        end
        @(negedge clk);
        rsp_ready[1] = 1'b1;
        @(negedge clk); #1;
        chk("bp.next.v", {31'b0, rsp_valid[1]}, 32'h1);
        chk("bp.next.a", rsp_addr[1], 32'h4);
      end
    join
    repeat (6) @(negedge clk);
    // flush with a same-edge request
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h10;
    @(negedge clk);
    req_addr[1] = 32'h14;
    @(negedge clk);
    req_addr[1] = 32'h40; flush[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0; flush[1] = 1'b0;
    #1 chk("fl.c1", {31'b0, rsp_valid[1]}, 32'h0);
    @(negedge clk); #1 chk("fl.c2", {31'b0, rsp_valid[1]}, 32'h0);
    @(negedge clk); #1 chk("fl.c3", {31'b0, rsp_valid[1]}, 32'h1);
    chk("fl.addr", rsp_addr[1], 32'h40);
    @(negedge clk); #1 chk("fl.c4", {31'b0, rsp_valid[1]}, 32'h0);
    // flush while the output stage is stalled
    @(negedge clk);
    rsp_ready[1] = 1'b0; req_valid[1] = 1'b1; req_addr[1] = 32'h20;
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("fs.v", {31'b0, rsp_valid[1]}, 32'h1);
    chk("fs.addr", rsp_addr[1], 32'h20);
    chk("fs.stall_rdy", {31'b0, req_ready[1]}, 32'h0);
    @(negedge clk);
    flush[1] = 1'b1;
    #1 chk("fs.flush_rdy", {31'b0, req_ready[1]}, 32'h1);
    @(negedge clk);
    flush[1] = 1'b0;
    #1 chk("fs.gone", {31'b0, rsp_valid[1]}, 32'h0);
    rsp_ready[1] = 1'b1;
    // asynchronous reset with requests in flight
    @(negedge clk);
    req_valid[1] = 1'b1; req_addr[1] = 32'h8;
    @(negedge clk);
    req_addr[1] = 32'hFFC;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk); #1;
    chk("ar.v", {31'b0, rsp_valid[1]}, 32'h1);
    chk("ar.d", rsp_data[1], 32'hDEADBEEF);
    #1 rst = 1'b1;
    #1;
    chk("ar.drop", {31'b0, rsp_valid[1]}, 32'h0);
    chk("ar.addr", rsp_addr[1], 32'h0);
    chk("ar.data", rsp_data[1], NOP);
    @(negedge clk);
    rst = 1'b0;
    fetch(1, 32'hFFC, 32'hCAFEF00D, 1'b0, "ar.keep0");
    fetch(1, 32'h8, 32'hDEADBEEF, 1'b0, "ar.keep1");
    repeat (6) @(negedge clk);
    chk("drain0", 32'(sb[0].q.size()), 32'h0);
    chk("drain1", 32'(sb[1].q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
